// File: rtl/instr_decoder.sv
// Instruction decoder: accepts 16-bit instruction words over valid/ready and
// drives a registered datapath control bundle; multiply occupies two cycles.
module instr_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] inst,
  input  logic        inst_valid,
  output logic        inst_ready,
  output logic [15:0] regEnable,
  output logic        flagEn,
  output logic        RorI,
  output logic [7:0]  opcode,
  output logic [3:0]  Rsrc,
  output logic [3:0]  Rdest,
  output logic [15:0] imm,
  output logic        ctrl_valid,
  output logic        illegal,
  output logic [15:0] issue_cnt,
  output logic [7:0]  illegal_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, MUL2} state_t;

  state_t      state, state_n;
  logic        mul_q, mul_n;
  logic        xfer;
  logic [3:0]  op, ext;

  logic        d_wr, d_flag, d_rori, d_mul, d_ill;
  logic [15:0] d_imm;

  logic [15:0] re_n, imm_n;
  logic        fe_n, ri_n, cv_n, il_n;
  logic [7:0]  opc_n;
  logic [3:0]  rs_n, rd_n;

  assign op         = inst[15:12];
  assign ext        = inst[7:4];
  assign inst_ready = (state != ISSUE) || !mul_q;
  assign xfer       = inst_valid && inst_ready;

  always_comb begin
    d_wr   = 1'b0;
    d_flag = 1'b0;
    d_rori = 1'b0;
    d_mul  = 1'b0;
    d_ill  = 1'b0;
    d_imm  = 16'h0000;
    case (op)
      4'h0: begin
        case (ext)
          4'h1, 4'h2, 4'h3, 4'h6, 4'hD: d_wr = 1'b1;
          4'h5, 4'h7, 4'h9, 4'hA: begin
            d_wr   = 1'b1;
            d_flag = 1'b1;
          end
          4'hB: d_flag = 1'b1;
          4'hE: begin
            d_wr  = 1'b1;
            d_mul = 1'b1;
          end
          default: d_ill = 1'b1;
        endcase
      end
      4'h1, 4'h2, 4'h3, 4'h6: begin
        d_wr   = 1'b1;
        d_rori = 1'b1;
        d_imm  = {8'h00, inst[7:0]};
      end
      4'h5, 4'h7, 4'h9, 4'hA: begin
        d_wr   = 1'b1;
        d_flag = 1'b1;
        d_rori = 1'b1;
        d_imm  = {{8{inst[7]}}, inst[7:0]};
      end
      4'hB: begin
        d_flag = 1'b1;
        d_rori = 1'b1;
        d_imm  = {{8{inst[7]}}, inst[7:0]};
      end
      4'hD, 4'hE: begin
        d_wr   = 1'b1;
        d_rori = 1'b1;
        d_mul  = (op == 4'hE);
        d_imm  = {{8{inst[7]}}, inst[7:0]};
      end
      4'h8: begin
        // Shift immediates borrow inst[4] as the sign bit of a 5-bit count.
        if (ext == 4'h4 || ext == 4'h6) begin
          d_wr = 1'b1;
        end else if (ext[3:2] == 2'b00) begin
          d_wr   = 1'b1;
          d_rori = 1'b1;
          d_imm  = {{11{inst[4]}}, inst[4:0]};
        end else begin
          d_ill = 1'b1;
        end
      end
      default: d_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_n = IDLE;
    mul_n   = 1'b0;
    re_n    = 16'h0000;
    fe_n    = 1'b0;
    ri_n    = 1'b0;
    opc_n   = 8'h00;
    rs_n    = 4'h0;
    rd_n    = 4'h0;
    imm_n   = 16'h0000;
    cv_n    = 1'b0;
    il_n    = 1'b0;
    if (xfer) begin
      state_n = ISSUE;
      cv_n    = 1'b1;
      if (d_ill) begin
        il_n = 1'b1;
      end else begin
        mul_n = d_mul;
        re_n  = (d_wr && !d_mul) ? (16'h0001 << inst[11:8]) : 16'h0000;
        fe_n  = d_flag;
        ri_n  = d_rori;
        opc_n = {op, ext};
        rs_n  = inst[3:0];
        rd_n  = inst[11:8];
        imm_n = d_imm;
      end
    end else if (state == ISSUE && mul_q) begin
      // Multiply result lands in the second cycle; operands stay put.
      state_n = MUL2;
      re_n    = 16'h0001 << Rdest;
      ri_n    = RorI;
      opc_n   = opcode;
      rs_n    = Rsrc;
      rd_n    = Rdest;
      imm_n   = imm;
      cv_n    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      mul_q       <= 1'b0;
      regEnable   <= 16'h0000;
      flagEn      <= 1'b0;
      RorI        <= 1'b0;
      opcode      <= 8'h00;
      Rsrc        <= 4'h0;
      Rdest       <= 4'h0;
      imm         <= 16'h0000;
      ctrl_valid  <= 1'b0;
      illegal     <= 1'b0;
      issue_cnt   <= 16'h0000;
      illegal_cnt <= 8'h00;
    end else begin
      state      <= state_n;
      mul_q      <= mul_n;
      regEnable  <= re_n;
      flagEn     <= fe_n;
      RorI       <= ri_n;
      opcode     <= opc_n;
      Rsrc       <= rs_n;
      Rdest      <= rd_n;
      imm        <= imm_n;
      ctrl_valid <= cv_n;
      illegal    <= il_n;
      if (xfer) issue_cnt <= issue_cnt + 16'd1;
      if (xfer && d_ill && illegal_cnt != 8'hFF) illegal_cnt <= illegal_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench for instr_decoder: directed scenarios plus randomized
// traffic compared against an instruction-table reference model.
module tb_instr_decoder;

  typedef struct packed {
    logic [15:0] re;
    logic        fe;
    logic        ri;
    logic [7:0]  opc;
    logic [3:0]  rs;
    logic [3:0]  rd;
    logic [15:0] im;
    logic        cv;
    logic        il;
  } bund_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] inst = 16'h0000;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [15:0] regEnable;
  logic        flagEn;
  logic        RorI;
  logic [7:0]  opcode;
  logic [3:0]  Rsrc;
  logic [3:0]  Rdest;
  logic [15:0] imm;
  logic        ctrl_valid;
  logic        illegal;
  logic [15:0] issue_cnt;
  logic [7:0]  illegal_cnt;

  int          n_chk = 0;
  int          n_fail = 0;

  bund_t       exp_b;
  logic        exp_ready;
  logic        mul_pend;
  logic [15:0] exp_issue;
  int          exp_ill;

  instr_decoder dut (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .regEnable(regEnable), .flagEn(flagEn),
    .RorI(RorI), .opcode(opcode), .Rsrc(Rsrc), .Rdest(Rdest), .imm(imm),
    .ctrl_valid(ctrl_valid), .illegal(illegal), .issue_cnt(issue_cnt),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  function automatic bund_t got_b();
    return {regEnable, flagEn, RorI, opcode, Rsrc, Rdest, imm, ctrl_valid, illegal};
  endfunction

  // Reference decode from the instruction table: first-cycle bundle of a word.
  function automatic bund_t first_b(input logic [15:0] i, output logic is_mul);
    logic [15:0] ok_set   = 16'h6EEE;  // AND OR XOR ADD ADDU ADDC SUB SUBC CMP MOV MUL
    logic [15:0] flag_set = 16'h0EA0;  // ADD ADDC SUB SUBC CMP
    logic [15:0] zext_set = 16'h004E;  // AND OR XOR ADDU
    logic [3:0]  op  = i[15:12];
    logic [3:0]  ext = i[7:4];
    logic        legal, wr, fe, ri;
    logic [15:0] im;
    bund_t       b;
    legal = 0; wr = 0; fe = 0; ri = 0; im = 0; is_mul = 0; b = '0;
    if (op == 4'h0) begin
      legal  = ok_set[ext];
      wr     = (ext != 4'hB);
      fe     = flag_set[ext];
      is_mul = legal && (ext == 4'hE);
    end else if (op == 4'h8) begin
      if (ext == 4'h4 || ext == 4'h6) begin
        legal = 1; wr = 1;
      end else if (ext < 4) begin
        legal = 1; wr = 1; ri = 1;
        im = i[4] ? (16'(i[4:0]) - 16'd32) : 16'(i[4:0]);
      end
    end else begin
      legal  = ok_set[op];
      wr     = (op != 4'hB);
      fe     = flag_set[op];
      ri     = 1;
      is_mul = legal && (op == 4'hE);
      if (zext_set[op]) im = 16'(i[7:0]);
      else im = i[7] ? (16'(i[7:0]) - 16'd256) : 16'(i[7:0]);
    end
    if (!legal) begin
      b.cv = 1; b.il = 1; is_mul = 0;
    end else begin
      b.re  = (wr && !is_mul) ? (16'd1 << i[11:8]) : 16'd0;
      b.fe  = fe;
      b.ri  = ri;
      b.opc = {op, ext};
      b.rs  = i[3:0];
      b.rd  = i[11:8];
      b.im  = im;
      b.cv  = 1;
    end
    return b;
  endfunction

  task automatic model_reset();
    exp_b = '0; exp_ready = 1; mul_pend = 0; exp_issue = 0; exp_ill = 0;
  endtask

  // Drives one cycle from the negedge phase and advances the model at posedge.
  task automatic step(input logic v, input logic [15:0] i);
    logic xfer, m;
    inst_valid = v;
    inst = i;
    xfer = v && exp_ready;
    @(posedge clk);
    if (xfer) begin
      exp_issue = exp_issue + 16'd1;
      exp_b = first_b(i, m);
      if (exp_b.il && exp_ill < 255) exp_ill++;
      mul_pend = m;
      exp_ready = !m;
    end else if (mul_pend) begin
      exp_b.re = 16'd1 << exp_b.rd;
      mul_pend = 0;
      exp_ready = 1;
    end else begin
      exp_b = '0;
      exp_ready = 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (got_b() !== exp_b || issue_cnt !== 16'd0 || illegal_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h cnt %h/%h, expected %h cnt 0/0", got_b(), issue_cnt, illegal_cnt, exp_b);
    end
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (inst_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, expected 1", inst_ready);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 16'h5101);
    n_chk++;
    if (got_b() !== exp_b || {regEnable, opcode, imm, RorI, flagEn} !== {16'h0002, 8'h50, 16'h0001, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL addi_r1: got %h, expected %h", got_b(), exp_b);
    end
    step(1, 16'h0251);
    n_chk++;
    if (got_b() !== exp_b || {regEnable, opcode, Rsrc, Rdest} !== {16'h0004, 8'h05, 4'h1, 4'h2}) begin
      n_fail++;
      $display("FAIL add_r2_r1: got %h, expected %h", got_b(), exp_b);
    end
    step(0, 16'h0000);
    n_chk++;
    if (got_b() !== 52'd0 || issue_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL b2b_idle: got %h cnt %h, expected 0 cnt 2", got_b(), issue_cnt);
    end
  endtask

  task automatic test_immediates();
    step(1, 16'h93FF);
    n_chk++;
    if (got_b() !== exp_b || imm !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL subi_sext: got %h imm %h, expected %h imm FFFF", got_b(), imm, exp_b);
    end
    step(1, 16'h13FF);
    n_chk++;
    if (got_b() !== exp_b || imm !== 16'h00FF || flagEn !== 1'b0) begin
      n_fail++;
      $display("FAIL andi_zext: got %h imm %h, expected %h imm 00FF", got_b(), imm, exp_b);
    end
    step(0, 16'h0000);
  endtask

  task automatic test_mul();
    step(1, 16'h04E5);
    n_chk++;
    if (got_b() !== exp_b || regEnable !== 16'h0000 || inst_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_issue: got %h rdy %b, expected %h rdy 0", got_b(), inst_ready, exp_b);
    end
    step(1, 16'h0251);
    n_chk++;
    if (got_b() !== exp_b || regEnable !== 16'h0010 || inst_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_mul2: got %h rdy %b, expected %h rdy 1", got_b(), inst_ready, exp_b);
    end
    step(1, 16'h0251);
    n_chk++;
    if (got_b() !== exp_b || regEnable !== 16'h0004) begin
      n_fail++;
      $display("FAIL mul_next: got %h, expected %h", got_b(), exp_b);
    end
    step(0, 16'h0000);
  endtask

  task automatic test_cmp_shift();
    step(1, 16'h06B7);
    n_chk++;
    if (got_b() !== exp_b || flagEn !== 1'b1 || regEnable !== 16'h0000) begin
      n_fail++;
      $display("FAIL cmp: got %h, expected %h", got_b(), exp_b);
    end
    step(1, 16'h821D);
    n_chk++;
    if (got_b() !== exp_b || imm !== 16'hFFFD || RorI !== 1'b1) begin
      n_fail++;
      $display("FAIL lshi_neg: got %h, expected %h", got_b(), exp_b);
    end
    step(0, 16'h0000);
  endtask

  task automatic test_illegal();
    step(1, 16'hF000);
    n_chk++;
    if (got_b() !== 52'd2 + 52'd1 || illegal_cnt !== 8'd1 || got_b() !== exp_b) begin
      n_fail++;
      $display("FAIL illegal_nop: got %h cnt %h, expected %h cnt 1", got_b(), illegal_cnt, exp_b);
    end
    step(0, 16'h0000);
    n_chk++;
    if (illegal !== 1'b0 || ctrl_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_pulse: illegal %b cv %b, expected 0 0", illegal, ctrl_valid);
    end
    for (int k = 0; k < 300; k++) begin
      step(1, 16'hF000);
      n_chk++;
      if (got_b() !== exp_b || illegal_cnt !== 8'(exp_ill)) begin
        n_fail++;
        $display("FAIL illegal_run %0d: got %h cnt %0d, expected %h cnt %0d", k, got_b(), illegal_cnt, exp_b, exp_ill);
      end
    end
    step(0, 16'h0000);
    n_chk++;
    if (illegal_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL illegal_sat: got %0d, expected 255", illegal_cnt);
    end
  endtask

  task automatic test_reset_mul2();
    step(1, 16'h0EE1);
    step(0, 16'h0000);
    n_chk++;
    if (regEnable !== 16'h4000) begin
      n_fail++;
      $display("FAIL pre_reset_mul2: got %h, expected 4000", regEnable);
    end
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_chk++;
    if (got_b() !== 52'd0 || issue_cnt !== 16'd0 || illegal_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mul2: got %h cnt %h/%h, expected 0 cnt 0/0", got_b(), issue_cnt, illegal_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(0, 16'h0000);
      n_chk++;
      if (got_b() !== 52'd0) begin
        n_fail++;
        $display("FAIL post_reset_quiet %0d: got %h, expected 0", k, got_b());
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]  ops [13] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hD, 4'hE};
    logic        v = 0;
    logic [15:0] i = 0;
    logic        rdy_before;
    for (int k = 0; k < 600; k++) begin
      rdy_before = exp_ready;
      if (!(v && !rdy_before)) begin
        v = ($urandom_range(0, 3) != 0);
        i = 16'($urandom);
        if ($urandom_range(0, 4) != 0) i[15:12] = ops[$urandom_range(0, 12)];
      end
      step(v, i);
      if (v && rdy_before) v = 0;
      n_chk++;
      if (got_b() !== exp_b || inst_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL rand_ctrl %0d inst %h: got %h rdy %b, expected %h rdy %b", k, i, got_b(), inst_ready, exp_b, exp_ready);
      end
      n_chk++;
      if (issue_cnt !== exp_issue || illegal_cnt !== 8'(exp_ill)) begin
        n_fail++;
        $display("FAIL rand_cnt %0d: got %h/%0d, expected %h/%0d", k, issue_cnt, illegal_cnt, exp_issue, exp_ill);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_immediates();
    test_mul();
    test_cmp_shift();
    test_illegal();
    test_reset_mul2();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
